// File: rtl/axil_mem_ctrl.sv
// AXI4-Lite slave sequencing a single-port synchronous RAM; one transaction in flight, round-robin read/write arbitration.
// Latency from handshake: read RVALID +3, full write BVALID +2, partial (RMW) +4, error/zero-strobe +1; responses held until ready.
module axil_mem_ctrl #(
    parameter int ADDR_WIDTH     = 6,
    parameter int DATA_WIDTH     = 32,
    parameter int AXI_ADDR_WIDTH = 32
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [AXI_ADDR_WIDTH-1:0] AWADDR,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [DATA_WIDTH-1:0]     WDATA,
    input  logic [DATA_WIDTH/8-1:0]   WSTRB,
    input  logic                      WVALID,
    output logic                      WREADY,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    input  logic [AXI_ADDR_WIDTH-1:0] ARADDR,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    output logic [DATA_WIDTH-1:0]     RDATA,
    output logic [1:0]                RRESP,
    output logic                      RVALID,
    input  logic                      RREADY,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wr_data,
    output logic                      mem_wr_en,
    input  logic [DATA_WIDTH-1:0]     mem_rd_data
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_MEM  = 3'd1;
    localparam logic [2:0] S_RD_CAP  = 3'd2;
    localparam logic [2:0] S_RD_RESP = 3'd3;
    localparam logic [2:0] S_WR_MEM  = 3'd4;
    localparam logic [2:0] S_WR_RESP = 3'd5;
    localparam logic [2:0] S_RMW_RD  = 3'd6;
    localparam logic [2:0] S_RMW_CAP = 3'd7;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [2:0]            state_q, state_d;
    logic                  prio_wr_q, prio_wr_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [1:0]            bresp_q, bresp_d;

    logic                  idle;
    logic                  wr_pend;
    logic                  rd_pend;
    logic                  grant_wr;
    logic                  grant_rd;
    logic                  aw_in_range;
    logic                  ar_in_range;
    logic [DATA_WIDTH-1:0] merged;

    assign idle        = (state_q == S_IDLE) && !RST;
    assign wr_pend     = AWVALID && WVALID;
    assign rd_pend     = ARVALID;
    // prio_wr_q says which side wins a tie; a lone requester always wins.
    assign grant_wr    = idle && wr_pend && (!rd_pend || prio_wr_q);
    assign grant_rd    = idle && rd_pend && (!wr_pend || !prio_wr_q);
    assign aw_in_range = (AWADDR >> (ADDR_WIDTH + 2)) == '0;
    assign ar_in_range = (ARADDR >> (ADDR_WIDTH + 2)) == '0;

    always_comb begin
        merged = mem_rd_data;
        for (int b = 0; b < STRB_WIDTH; b++) begin
            if (wstrb_q[b]) begin
                merged[8*b +: 8] = wdata_q[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        prio_wr_d     = prio_wr_q;
        mem_addr_d    = mem_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        rdata_d       = rdata_q;
        rresp_d       = rresp_q;
        bresp_d       = bresp_q;
        case (state_q)
            S_IDLE: begin
                if (grant_wr) begin
                    prio_wr_d = 1'b0;
                    wdata_d   = WDATA;
                    wstrb_d   = WSTRB;
                    if (!aw_in_range) begin
                        bresp_d = RESP_SLVERR;
                        state_d = S_WR_RESP;
                    end else if (WSTRB == '0) begin
                        bresp_d = RESP_OKAY;
                        state_d = S_WR_RESP;
                    end else begin
                        bresp_d    = RESP_OKAY;
                        mem_addr_d = AWADDR[ADDR_WIDTH+1:2];
                        if (&WSTRB) begin
                            mem_wr_data_d = WDATA;
                            state_d       = S_WR_MEM;
                        end else begin
                            state_d = S_RMW_RD;
                        end
                    end
                end else if (grant_rd) begin
                    prio_wr_d = 1'b1;
                    if (!ar_in_range) begin
                        rresp_d = RESP_SLVERR;
                        rdata_d = '0;
                        state_d = S_RD_RESP;
                    end else begin
                        rresp_d    = RESP_OKAY;
                        mem_addr_d = ARADDR[ADDR_WIDTH+1:2];
                        state_d    = S_RD_MEM;
                    end
                end
            end
            S_RD_MEM:  state_d = S_RD_CAP;
            S_RD_CAP: begin
                rdata_d = mem_rd_data;
                state_d = S_RD_RESP;
            end
            S_RD_RESP: if (RREADY) state_d = S_IDLE;
            S_WR_MEM:  state_d = S_WR_RESP;
            S_WR_RESP: if (BREADY) state_d = S_IDLE;
            S_RMW_RD:  state_d = S_RMW_CAP;
            S_RMW_CAP: begin
                mem_wr_data_d = merged;
                state_d       = S_WR_MEM;
            end
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= S_IDLE;
            prio_wr_q     <= 1'b1;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            rdata_q       <= '0;
            rresp_q       <= RESP_OKAY;
            bresp_q       <= RESP_OKAY;
        end else begin
            state_q       <= state_d;
            prio_wr_q     <= prio_wr_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            rdata_q       <= rdata_d;
            rresp_q       <= rresp_d;
            bresp_q       <= bresp_d;
        end
    end

    assign AWREADY     = grant_wr;
    assign WREADY      = grant_wr;
    assign ARREADY     = grant_rd;
    assign BVALID      = (state_q == S_WR_RESP);
    assign BRESP       = bresp_q;
    assign RVALID      = (state_q == S_RD_RESP);
    assign RRESP       = rresp_q;
    assign RDATA       = rdata_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wr_data = mem_wr_data_q;
    // Gated by RST so an abandoned write never reaches the array.
    assign mem_wr_en   = (state_q == S_WR_MEM) && !RST;

endmodule

// File: tb/tb_axil_mem_ctrl.sv
// Bench for axil_mem_ctrl: directed scenarios plus randomized traffic checked against a word-array memory model.
`timescale 1ns/1ps
module tb_axil_mem_ctrl;
    localparam int AW = 6;
    localparam int DW = 32;
    localparam int XW = 32;

    logic          CLK = 1'b0;
    logic          RST;
    logic [XW-1:0] AWADDR;
    logic          AWVALID;
    logic          AWREADY;
    logic [DW-1:0] WDATA;
    logic [3:0]    WSTRB;
    logic          WVALID;
    logic          WREADY;
    logic [1:0]    BRESP;
    logic          BVALID;
    logic          BREADY;
    logic [XW-1:0] ARADDR;
    logic          ARVALID;
    logic          ARREADY;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;
    logic          RVALID;
    logic          RREADY;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic          mem_wr_en;
    logic [DW-1:0] mem_rd_data;

    always #5 CLK = ~CLK;

    axil_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AXI_ADDR_WIDTH(XW)) dut (
        .CLK(CLK), .RST(RST),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
        .mem_rd_data(mem_rd_data)
    );

    // Physical RAM the controller drives.
    logic [DW-1:0] tb_mem [0:63];
    always @(posedge CLK) begin
        if (mem_wr_en) tb_mem[mem_addr] <= mem_wr_data;
        else           mem_rd_data <= tb_mem[mem_addr];
    end

    // Expected memory contents, updated only from transaction semantics.
    logic [DW-1:0] ref_mem [0:63];

    int checks = 0;
    int failures = 0;

    int edge_cnt = 0;
    int wr_cnt = 0;
    int last_wr_edge = -1;
    int hs_edge = -1;
    int dbl_grant = 0;
    logic [AW-1:0] last_wr_addr;
    logic [DW-1:0] last_wr_data;
    int grant_q[$];
    logic mon_w, mon_r;

    always @(posedge CLK) begin
        if (mem_wr_en) begin
            wr_cnt++;
            last_wr_edge = edge_cnt;
            last_wr_addr = mem_addr;
            last_wr_data = mem_wr_data;
        end
        mon_w = AWVALID && AWREADY && WVALID && WREADY;
        mon_r = ARVALID && ARREADY;
        if (mon_w && mon_r) dbl_grant++;
        if (mon_w) begin grant_q.push_back(1); hs_edge = edge_cnt; end
        if (mon_r) begin grant_q.push_back(2); hs_edge = edge_cnt; end
        edge_cnt++;
    end

    function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                                   input logic [3:0] s);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 0; RREADY = 0;
        repeat (3) tick();
        RST = 1'b0;
        #1;
    endtask

    task automatic do_write(input logic [XW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                            input int hold, output int lat, output logic [1:0] resp, output logic acc);
        int n;
        AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1; WVALID = 1; BREADY = 0;
        #1;
        n = 0;
        while (!(AWREADY && WREADY) && n < 20) begin tick(); n++; end
        acc = AWREADY && WREADY;
        tick();
        AWVALID = 0; WVALID = 0;
        lat = 1;
        while (!BVALID && lat < 20) begin tick(); lat++; end
        if (!BVALID) lat = -1;
        resp = BRESP;
        repeat (hold) tick();
        BREADY = 1; tick(); BREADY = 0;
    endtask

    task automatic do_read(input logic [XW-1:0] a, input int hold, output int lat, output logic [DW-1:0] data,
                           output logic [1:0] resp, output logic acc, output int unstable);
        int n;
        ARADDR = a; ARVALID = 1; RREADY = 0;
        #1;
        n = 0;
        while (!ARREADY && n < 20) begin tick(); n++; end
        acc = ARREADY;
        tick();
        ARVALID = 0;
        lat = 1;
        while (!RVALID && lat < 20) begin tick(); lat++; end
        if (!RVALID) lat = -1;
        data = RDATA;
        resp = RRESP;
        unstable = 0;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (!RVALID || RDATA !== data || RRESP !== resp) unstable++;
        end
        RREADY = 1; tick(); RREADY = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, mem_wr_en} !== 6'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b exp=000000", {AWREADY, WREADY, ARREADY, BVALID, RVALID, mem_wr_en});
        end
        checks++;
        if ({BRESP, RRESP} !== 4'b0) begin failures++; $display("FAIL reset_resp got=%b exp=0000", {BRESP, RRESP}); end
        checks++;
        if (RDATA !== '0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", RDATA); end
        checks++;
        if (mem_addr !== '0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        checks++;
        if (mem_wr_data !== '0) begin failures++; $display("FAIL reset_mem_wr_data got=%h exp=0", mem_wr_data); end
    endtask

    task automatic test_full_write();
        int lat, e0; logic [1:0] resp; logic acc;
        e0 = wr_cnt;
        do_write(32'h10, 32'hDEADBEEF, 4'hF, 0, lat, resp, acc);
        ref_mem[4] = 32'hDEADBEEF;
        checks++; if (acc !== 1'b1) begin failures++; $display("FAIL full_wr_accept got=%b exp=1", acc); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL full_wr_bvalid_lat got=%0d exp=2", lat); end
        checks++; if (resp !== 2'b00) begin failures++; $display("FAIL full_wr_bresp got=%b exp=00", resp); end
        checks++; if (wr_cnt !== e0 + 1) begin failures++; $display("FAIL full_wr_count got=%0d exp=%0d", wr_cnt, e0 + 1); end
        checks++; if (last_wr_edge !== hs_edge + 1) begin
            failures++; $display("FAIL full_wr_en_cycle got=%0d exp=%0d", last_wr_edge, hs_edge + 1);
        end
        checks++; if (last_wr_addr !== 6'd4) begin failures++; $display("FAIL full_wr_addr got=%0d exp=4", last_wr_addr); end
        checks++; if (last_wr_data !== 32'hDEADBEEF) begin
            failures++; $display("FAIL full_wr_data got=%h exp=deadbeef", last_wr_data);
        end
    endtask

    task automatic test_read_hold();
        int lat, unst; logic [DW-1:0] d; logic [1:0] resp; logic acc;
        do_read(32'h10, 5, lat, d, resp, acc, unst);
        checks++; if (lat !== 3) begin failures++; $display("FAIL rd_rvalid_lat got=%0d exp=3", lat); end
        checks++; if (d !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h exp=deadbeef", d); end
        checks++; if (resp !== 2'b00) begin failures++; $display("FAIL rd_rresp got=%b exp=00", resp); end
        checks++; if (unst !== 0) begin failures++; $display("FAIL rd_hold_stable got=%0d exp=0", unst); end
    endtask

    task automatic test_partial();
        int lat, e0, unst; logic [1:0] resp; logic acc; logic [DW-1:0] d;
        do_write(32'h08, 32'h11223344, 4'hF, 0, lat, resp, acc);
        ref_mem[2] = 32'h11223344;
        e0 = wr_cnt;
        do_write(32'h08, 32'hAABBCCDD, 4'b0101, 1, lat, resp, acc);
        ref_mem[2] = merge_bytes(ref_mem[2], 32'hAABBCCDD, 4'b0101);
        checks++; if (lat !== 4) begin failures++; $display("FAIL rmw_bvalid_lat got=%0d exp=4", lat); end
        checks++; if (wr_cnt !== e0 + 1) begin failures++; $display("FAIL rmw_wr_count got=%0d exp=%0d", wr_cnt, e0 + 1); end
        checks++; if (last_wr_edge !== hs_edge + 3) begin
            failures++; $display("FAIL rmw_wr_cycle got=%0d exp=%0d", last_wr_edge, hs_edge + 3);
        end
        checks++; if (last_wr_data !== 32'h11BB33DD) begin failures++; $display("FAIL rmw_wr_data got=%h exp=11bb33dd", last_wr_data); end
        do_read(32'h08, 0, lat, d, resp, acc, unst);
        checks++; if (d !== 32'h11BB33DD) begin failures++; $display("FAIL rmw_readback got=%h exp=11bb33dd", d); end
        e0 = wr_cnt;
        do_write(32'h08, 32'h99999999, 4'b0000, 0, lat, resp, acc);
        checks++; if (lat !== 1) begin failures++; $display("FAIL zero_strb_lat got=%0d exp=1", lat); end
        checks++; if (wr_cnt !== e0) begin failures++; $display("FAIL zero_strb_wr_count got=%0d exp=%0d", wr_cnt, e0); end
    endtask

    task automatic test_oor();
        int lat, e0, unst; logic [1:0] resp; logic acc; logic [DW-1:0] d;
        e0 = wr_cnt;
        do_read(32'h100, 0, lat, d, resp, acc, unst);
        checks++; if (lat !== 1) begin failures++; $display("FAIL oor_rd_lat got=%0d exp=1", lat); end
        checks++; if (resp !== 2'b10) begin failures++; $display("FAIL oor_rd_resp got=%b exp=10", resp); end
        checks++; if (d !== '0) begin failures++; $display("FAIL oor_rd_data got=%h exp=0", d); end
        do_write(32'h100, 32'h12345678, 4'hF, 2, lat, resp, acc);
        checks++; if (lat !== 1) begin failures++; $display("FAIL oor_wr_lat got=%0d exp=1", lat); end
        checks++; if (resp !== 2'b10) begin failures++; $display("FAIL oor_wr_resp got=%b exp=10", resp); end
        checks++; if (wr_cnt !== e0) begin failures++; $display("FAIL oor_wr_count got=%0d exp=%0d", wr_cnt, e0); end
    endtask

    task automatic test_arbitration();
        int d0, ng;
        do_reset();
        grant_q.delete();
        d0 = dbl_grant;
        AWADDR = 32'h3C; WDATA = 32'h0BADF00D; WSTRB = 4'hF; ARADDR = 32'h3C;
        BREADY = 1; RREADY = 1;
        AWVALID = 1; WVALID = 1; ARVALID = 1;
        repeat (30) tick();
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        repeat (8) tick();
        BREADY = 0; RREADY = 0;
        ref_mem[15] = 32'h0BADF00D;
        ng = grant_q.size();
        checks++; if (ng < 6) begin failures++; $display("FAIL arb_grant_count got=%0d exp>=6", ng); end
        checks++; if (dbl_grant !== d0) begin failures++; $display("FAIL arb_double_grant got=%0d exp=%0d", dbl_grant, d0); end
        for (int i = 0; i < ng && i < 6; i++) begin
            checks++;
            if (grant_q[i] !== ((i % 2 == 0) ? 1 : 2)) begin
                failures++; $display("FAIL arb_order[%0d] got=%0d exp=%0d (1=wr 2=rd)", i, grant_q[i], (i % 2 == 0) ? 1 : 2);
            end
        end
    endtask

    task automatic test_reset_mid();
        int lat, e0, n, bv, unst; logic [1:0] resp; logic acc; logic [DW-1:0] d;
        do_write(32'h20, 32'h5A5A5A5A, 4'hF, 0, lat, resp, acc);
        ref_mem[8] = 32'h5A5A5A5A;
        e0 = wr_cnt;
        AWADDR = 32'h20; WDATA = 32'hFFFF0000; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
        #1;
        n = 0;
        while (!(AWREADY && WREADY) && n < 20) begin tick(); n++; end
        tick();
        AWVALID = 0; WVALID = 0;
        RST = 1;
        #1;
        checks++; if (mem_wr_en !== 1'b0) begin failures++; $display("FAIL rst_mid_wr_en got=%b exp=0", mem_wr_en); end
        tick();
        RST = 0;
        #1;
        checks++;
        if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, mem_wr_en, BRESP, RRESP} !== 10'b0) begin
            failures++; $display("FAIL rst_mid_outputs got=%b exp=0", {AWREADY, WREADY, ARREADY, BVALID, RVALID, mem_wr_en, BRESP, RRESP});
        end
        bv = 0;
        repeat (4) begin tick(); if (BVALID) bv++; end
        checks++; if (bv !== 0) begin failures++; $display("FAIL rst_mid_bvalid got=%0d exp=0", bv); end
        checks++; if (wr_cnt !== e0) begin failures++; $display("FAIL rst_mid_wr_count got=%0d exp=%0d", wr_cnt, e0); end
        do_read(32'h20, 0, lat, d, resp, acc, unst);
        checks++; if (d !== ref_mem[8]) begin failures++; $display("FAIL rst_mid_mem got=%h exp=%h", d, ref_mem[8]); end
    endtask

    task automatic test_random();
        int idx, lat, e0, hold, exp_lat, unst;
        logic oor, is_wr, acc;
        logic [XW-1:0] a;
        logic [DW-1:0] d, got;
        logic [3:0] s;
        logic [1:0] resp, exp_resp;
        for (int i = 0; i < 60; i++) begin
            idx = $urandom_range(0, 63);
            oor = ($urandom_range(0, 7) == 0);
            a = (32'(idx) << 2) | 32'($urandom_range(0, 3));
            if (oor) a = a | (32'h1 << $urandom_range(XW - 1, AW + 2));
            is_wr = $urandom_range(0, 1) == 1;
            hold = $urandom_range(0, 3);
            d = $urandom;
            case ($urandom_range(0, 3))
                0: s = 4'hF;
                1: s = 4'h0;
                default: s = 4'($urandom_range(0, 15));
            endcase
            exp_resp = oor ? 2'b10 : 2'b00;
            e0 = wr_cnt;
            if (is_wr) begin
                exp_lat = (oor || s == 4'h0) ? 1 : (s == 4'hF) ? 2 : 4;
                do_write(a, d, s, hold, lat, resp, acc);
                if (!oor && s != 4'h0) ref_mem[idx] = merge_bytes(ref_mem[idx], d, s);
                checks++;
                if (wr_cnt - e0 !== ((!oor && s != 4'h0) ? 1 : 0)) begin
                    failures++; $display("FAIL rand_wr_count[%0d] got=%0d exp=%0d", i, wr_cnt - e0, (!oor && s != 4'h0) ? 1 : 0);
                end
            end else begin
                exp_lat = oor ? 1 : 3;
                do_read(a, hold, lat, got, resp, acc, unst);
                checks++;
                if (got !== (oor ? 32'h0 : ref_mem[idx])) begin
                    failures++; $display("FAIL rand_rd_data[%0d] addr=%h got=%h exp=%h", i, a, got, oor ? 32'h0 : ref_mem[idx]);
                end
            end
            checks++;
            if (lat !== exp_lat) begin failures++; $display("FAIL rand_lat[%0d] wr=%b got=%0d exp=%0d", i, is_wr, lat, exp_lat); end
            checks++;
            if (resp !== exp_resp) begin failures++; $display("FAIL rand_resp[%0d] got=%b exp=%b", i, resp, exp_resp); end
        end
    endtask

    initial begin
        logic [DW-1:0] v;
        RST = 1; AWADDR = 0; AWVALID = 0; WDATA = 0; WSTRB = 0; WVALID = 0; BREADY = 0;
        ARADDR = 0; ARVALID = 0; RREADY = 0;
        for (int i = 0; i < 64; i++) begin
            v = $urandom;
            tb_mem[i] <= v;
            ref_mem[i] = v;
        end
        test_reset();
        test_full_write();
        test_read_hold();
        test_partial();
        test_oor();
        test_arbitration();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
